// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RISC-V core: byte-serial loads/stores on an 8-bit port,
// ALU results passed through, registered writeback triple for the register file.
module mem_stage #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               ex_valid,
   output logic               ex_ready,
   input  logic               ex_wreg,
   input  logic [RADDR_W-1:0] ex_wd,
   input  logic [DATA_W-1:0]  ex_wdata,
   input  logic [3:0]         ex_memop,
   input  logic [ADDR_W-1:0]  ex_addr,
   input  logic [DATA_W-1:0]  ex_sdata,
   output logic               mem_req,
   output logic               mem_wr,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [7:0]         mem_dout,
   input  logic [7:0]         mem_din,
   input  logic               mem_ack,
   output logic               stall_req,
   output logic               wb_we,
   output logic [RADDR_W-1:0] wb_waddr,
   output logic [DATA_W-1:0]  wb_wdata
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   function automatic logic is_load(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_LHU);
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   function automatic logic [1:0] last_byte(input logic [3:0] op);
      case (op)
         OP_LH, OP_LHU, OP_SH: return 2'd1;
         OP_LW, OP_SW:         return 2'd3;
         default:              return 2'd0;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] extend(input logic [3:0] op, input logic [DATA_W-1:0] v);
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      sb = v[7:0];
      sh = v[15:0];
      case (op)
         OP_LB:   return DATA_W'(sb);
         OP_LH:   return DATA_W'(sh);
         OP_LBU:  return {{(DATA_W-8){1'b0}}, v[7:0]};
         OP_LHU:  return {{(DATA_W-16){1'b0}}, v[15:0]};
         default: return v;
      endcase
   endfunction

   state_t              state;
   logic [1:0]          cnt;
   logic [1:0]          last;
   logic [3:0]          op;
   logic [ADDR_W-1:0]   base;
   logic [DATA_W-1:0]   sdata;
   logic [DATA_W-1:0]   ld_buf;
   logic [RADDR_W-1:0]  rd;
   logic                wb_we_q;
   logic                access;
   logic                take;
   logic [DATA_W-1:0]   merged;

   assign access    = (state == ACCESS);
   assign ex_ready  = (state == IDLE) & rst & rdy;
   assign take      = ex_valid & ex_ready;
   assign stall_req = access;
   assign mem_req   = access & rdy;
   assign mem_wr    = access & is_store(op);
   assign mem_addr  = access ? base + ADDR_W'(cnt) : '0;
   assign mem_dout  = (access & is_store(op)) ? sdata[{cnt, 3'b000} +: 8] : 8'h00;
   // Register holds while frozen, so the pulse is masked rather than lost
   assign wb_we     = wb_we_q & rdy;

   // Final byte is merged combinationally so the writeback lands on the last-ack edge
   always_comb begin
      merged = ld_buf;
      merged[{cnt, 3'b000} +: 8] = mem_din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         last     <= '0;
         op       <= '0;
         base     <= '0;
         sdata    <= '0;
         ld_buf   <= '0;
         rd       <= '0;
         wb_we_q  <= 1'b0;
         wb_waddr <= '0;
         wb_wdata <= '0;
      end else if (rdy) begin
         wb_we_q <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  if (is_load(ex_memop) || is_store(ex_memop)) begin
                     op     <= ex_memop;
                     base   <= ex_addr;
                     sdata  <= ex_sdata;
                     rd     <= ex_wd;
                     last   <= last_byte(ex_memop);
                     cnt    <= '0;
                     ld_buf <= '0;
                     state  <= ACCESS;
                  end else begin
                     wb_we_q  <= ex_wreg;
                     wb_waddr <= ex_wd;
                     wb_wdata <= ex_wdata;
                  end
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  if (is_load(op)) ld_buf <= merged;
                  if (cnt == last) begin
                     state <= IDLE;
                     if (is_load(op)) begin
                        wb_we_q  <= 1'b1;
                        wb_waddr <= rd;
                        wb_wdata <= extend(op, merged);
                     end
                  end else begin
                     cnt <= cnt + 2'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized transactions
// compared against a byte-level reference model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        ex_valid;
   logic        ex_ready;
   logic        ex_wreg;
   logic [4:0]  ex_wd;
   logic [31:0] ex_wdata;
   logic [3:0]  ex_memop;
   logic [31:0] ex_addr;
   logic [31:0] ex_sdata;
   logic        mem_req;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        mem_ack;
   logic        stall_req;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;

   int nvec = 0;
   int nerr = 0;

   mem_stage #(.ADDR_W(32), .DATA_W(32), .RADDR_W(5)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wreg(ex_wreg), .ex_wd(ex_wd),
      .ex_wdata(ex_wdata), .ex_memop(ex_memop), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_din(mem_din), .mem_ack(mem_ack), .stall_req(stall_req),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic wreg, input logic [4:0] wd, input logic [31:0] wdata);
      ex_valid = 1'b1; ex_memop = op; ex_addr = addr; ex_sdata = sd;
      ex_wreg = wreg; ex_wd = wd; ex_wdata = wdata;
   endtask

   task automatic test_reset();
      rst = 1'b0; rdy = 1'b1; ex_valid = 1'b0; ex_wreg = 1'b0; ex_wd = '0; ex_wdata = '0;
      ex_memop = '0; ex_addr = '0; ex_sdata = '0; mem_din = '0; mem_ack = 1'b0;
      #3;
      nvec++;
      if ({mem_req, mem_wr, mem_addr, mem_dout, wb_we, wb_waddr, wb_wdata, stall_req, ex_ready} !== '0) begin
         nerr++;
         $display("FAIL reset_outputs: got req=%b wr=%b addr=%h dout=%h we=%b wa=%0d wd=%h stall=%b ready=%b, need all 0",
                  mem_req, mem_wr, mem_addr, mem_dout, wb_we, wb_waddr, wb_wdata, stall_req, ex_ready);
      end
      tick(); tick();
      rst = 1'b1;
      #1;
      nvec++;
      if (ex_ready !== 1'b1) begin
         nerr++;
         $display("FAIL reset_release_ready: got %b need 1", ex_ready);
      end
   endtask

   task automatic test_alu();
      present(4'd0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h12345678);
      tick();
      nvec++;
      if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd5, 32'h12345678} || ex_ready !== 1'b1) begin
         nerr++;
         $display("FAIL alu_first: got we=%b wa=%0d wd=%h ready=%b need 1/5/12345678/1", wb_we, wb_waddr, wb_wdata, ex_ready);
      end
      present(4'd12, 32'h0, 32'h0, 1'b1, 5'd6, 32'hCAFEBABE);
      tick();
      nvec++;
      if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd6, 32'hCAFEBABE}) begin
         nerr++;
         $display("FAIL alu_back_to_back: got we=%b wa=%0d wd=%h need 1/6/cafebabe", wb_we, wb_waddr, wb_wdata);
      end
      ex_valid = 1'b0;
      tick();
      nvec++;
      if (wb_we !== 1'b0) begin
         nerr++;
         $display("FAIL alu_pulse_width: got we=%b need 0", wb_we);
      end
   endtask

   task automatic test_lb_sign();
      logic [3:0]  ops [2] = '{4'd1, 4'd4};
      logic [31:0] exp [2] = '{32'hFFFFFF80, 32'h00000080};
      for (int k = 0; k < 2; k++) begin
         present(ops[k], 32'h100, 32'h0, 1'b0, 5'd9, 32'h0);
         tick();
         ex_valid = 1'b0;
         #1;
         nvec++;
         if ({mem_req, mem_wr, mem_addr, stall_req} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
            nerr++;
            $display("FAIL lb_wait_drive[%0d]: got req=%b wr=%b addr=%h stall=%b need 1/0/100/1", k, mem_req, mem_wr, mem_addr, stall_req);
         end
         tick();
         mem_ack = 1'b1; mem_din = 8'h80;
         tick();
         mem_ack = 1'b0;
         nvec++;
         if ({wb_we, wb_waddr, wb_wdata, mem_req} !== {1'b1, 5'd9, exp[k], 1'b0}) begin
            nerr++;
            $display("FAIL lb_result[%0d]: got we=%b wa=%0d wd=%h req=%b need 1/9/%h/0", k, wb_we, wb_waddr, wb_wdata, mem_req, exp[k]);
         end
      end
   endtask

   task automatic test_misaligned_lw();
      present(4'd3, 32'h00000001, 32'h0, 1'b0, 5'd3, 32'h0);
      tick();
      ex_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_ack = 1'b1; mem_din = 8'(8'h11 * (i + 1));
         #1;
         nvec++;
         if (mem_addr !== 32'(1 + i) || stall_req !== 1'b1 || mem_req !== 1'b1) begin
            nerr++;
            $display("FAIL lw_byte[%0d]: got addr=%h stall=%b req=%b need addr=%h stall=1 req=1", i, mem_addr, stall_req, mem_req, 32'(1 + i));
         end
         tick();
      end
      mem_ack = 1'b0;
      nvec++;
      if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd3, 32'h44332211}) begin
         nerr++;
         $display("FAIL lw_result: got we=%b wa=%0d wd=%h need 1/3/44332211", wb_we, wb_waddr, wb_wdata);
      end
   endtask

   task automatic test_sw_wrap();
      logic [31:0] ea [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      logic [7:0]  ed [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      present(4'd8, 32'hFFFFFFFE, 32'hAABBCCDD, 1'b1, 5'd4, 32'h0);
      tick();
      ex_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_ack = 1'b1;
         #1;
         nvec++;
         if ({mem_addr, mem_dout, mem_wr, mem_req, wb_we} !== {ea[i], ed[i], 1'b1, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL sw_byte[%0d]: got addr=%h dout=%h wr=%b req=%b we=%b need %h/%h/1/1/0",
                     i, mem_addr, mem_dout, mem_wr, mem_req, wb_we, ea[i], ed[i]);
         end
         tick();
      end
      mem_ack = 1'b0;
      nvec++;
      if (wb_we !== 1'b0 || ex_ready !== 1'b1) begin
         nerr++;
         $display("FAIL sw_end: got we=%b ready=%b need 0/1", wb_we, ex_ready);
      end
   endtask

   task automatic test_rdy_pause();
      present(4'd2, 32'h200, 32'h0, 1'b0, 5'd7, 32'h0);
      tick();
      ex_valid = 1'b0;
      mem_ack = 1'b1; mem_din = 8'h34;
      tick();
      rdy = 1'b0; mem_din = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         #1;
         nvec++;
         if (mem_req !== 1'b0 || wb_we !== 1'b0 || ex_ready !== 1'b0) begin
            nerr++;
            $display("FAIL rdy_pause[%0d]: got req=%b we=%b ready=%b need 0/0/0", i, mem_req, wb_we, ex_ready);
         end
         tick();
      end
      rdy = 1'b1; mem_din = 8'h92;
      #1;
      nvec++;
      if (mem_addr !== 32'h201 || mem_req !== 1'b1) begin
         nerr++;
         $display("FAIL rdy_resume_addr: got addr=%h req=%b need 201/1", mem_addr, mem_req);
      end
      tick();
      mem_ack = 1'b0;
      nvec++;
      if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd7, 32'hFFFF9234}) begin
         nerr++;
         $display("FAIL rdy_result: got we=%b wa=%0d wd=%h need 1/7/ffff9234", wb_we, wb_waddr, wb_wdata);
      end
   endtask

   task automatic test_reset_mid();
      present(4'd3, 32'h300, 32'h0, 1'b0, 5'd8, 32'h0);
      tick();
      ex_valid = 1'b0;
      mem_ack = 1'b1; mem_din = 8'hA1;
      tick();
      mem_din = 8'hB2;
      #2;
      rst = 1'b0;
      #1;
      nvec++;
      if ({mem_req, mem_wr, mem_addr, mem_dout, wb_we, wb_waddr, wb_wdata, stall_req, ex_ready} !== '0) begin
         nerr++;
         $display("FAIL reset_mid_outputs: got req=%b addr=%h stall=%b we=%b ready=%b need all 0",
                  mem_req, mem_addr, stall_req, wb_we, ex_ready);
      end
      tick(); tick();
      rst = 1'b1; mem_ack = 1'b0;
      #1;
      nvec++;
      if (ex_ready !== 1'b1 || mem_req !== 1'b0) begin
         nerr++;
         $display("FAIL reset_mid_ready: got ready=%b req=%b need 1/0", ex_ready, mem_req);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         nvec++;
         if (wb_we !== 1'b0 || mem_req !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid_quiet[%0d]: got we=%b req=%b need 0/0", i, wb_we, mem_req);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] addr, sd, wdata, val, expv, ea;
      logic [4:0]  wd;
      logic        wreg;
      logic [7:0]  b;
      int          n;
      for (int t = 0; t < 80; t++) begin
         op    = 4'($urandom_range(0, 10));
         addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
         sd    = $urandom; wdata = $urandom; wd = 5'($urandom); wreg = 1'($urandom);
         nvec++;
         if (ex_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rnd_ready[%0d]: got %b need 1", t, ex_ready);
         end
         present(op, addr, sd, wreg, wd, wdata);
         tick();
         ex_valid = 1'b0;
         if (op == 0 || op > 8) begin
            nvec++;
            if ({wb_we, wb_waddr, wb_wdata} !== {wreg, wd, wdata}) begin
               nerr++;
               $display("FAIL rnd_alu[%0d]: got we=%b wa=%0d wd=%h need %b/%0d/%h", t, wb_we, wb_waddr, wb_wdata, wreg, wd, wdata);
            end
            continue;
         end
         n = (op == 1 || op == 4 || op == 6) ? 1 : (op == 3 || op == 8) ? 4 : 2;
         val = '0;
         for (int i = 0; i < n; i++) begin
            ea = addr + 32'(i);
            for (int w = $urandom_range(0, 2); w > 0; w--) begin
               tick();
               nvec++;
               if (mem_req !== 1'b1 || mem_addr !== ea || stall_req !== 1'b1) begin
                  nerr++;
                  $display("FAIL rnd_hold[%0d.%0d]: got req=%b addr=%h stall=%b need 1/%h/1", t, i, mem_req, mem_addr, stall_req, ea);
               end
            end
            b = 8'($urandom);
            val[8*i +: 8] = b;
            mem_ack = 1'b1; mem_din = b;
            #1;
            nvec++;
            if (mem_req !== 1'b1 || mem_addr !== ea || mem_wr !== (op >= 6) ||
                (op >= 6 && mem_dout !== sd[8*i +: 8])) begin
               nerr++;
               $display("FAIL rnd_byte[%0d.%0d]: got req=%b addr=%h wr=%b dout=%h need addr=%h dout=%h",
                        t, i, mem_req, mem_addr, mem_wr, mem_dout, ea, sd[8*i +: 8]);
            end
            tick();
            mem_ack = 1'b0;
         end
         case (op)
            4'd1:    expv = 32'($signed(val[7:0]));
            4'd2:    expv = 32'($signed(val[15:0]));
            4'd4:    expv = {24'h0, val[7:0]};
            4'd5:    expv = {16'h0, val[15:0]};
            default: expv = val;
         endcase
         nvec++;
         if (op >= 6) begin
            if (wb_we !== 1'b0) begin
               nerr++;
               $display("FAIL rnd_store_wb[%0d]: got we=%b need 0", t, wb_we);
            end
         end else if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, wd, expv}) begin
            nerr++;
            $display("FAIL rnd_load[%0d] op=%0d: got we=%b wa=%0d wd=%h need 1/%0d/%h", t, op, wb_we, wb_waddr, wb_wdata, wd, expv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_lb_sign();
      test_misaligned_lw();
      test_sw_wrap();
      test_rdy_pause();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within bound");
      $fatal(1, "timeout");
   end

endmodule
